// File: rtl/serial_rx_sipo_if.sv
// Serial receive link bundle: line input from the sender side, parallel word and status
// strobes toward the consumer.
interface serial_rx_sipo_if #(
    parameter int WIDTH = 8
);
    logic             rx;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             parity_err;
    logic             frame_err;
    logic             busy;

    modport master (
        output rx,
        input  data_out, valid, parity_err, frame_err, busy
    );

    modport slave (
        input  rx,
        output data_out, valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/serial_rx_sipo.sv
// Start/data(LSB-first)/even-parity/stop frame receiver; valid strobes one cycle after the stop sample.
// No backpressure: each completed word overwrites data_out and is flagged by a single valid pulse.
module serial_rx_sipo #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             res,
    serial_rx_sipo_if.slave  bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW   = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             perr_q, perr_d;
    logic             valid_q, valid_d;
    logic             par_err_q, par_err_d;
    logic             frm_err_q, frm_err_d;

    assign bus.data_out   = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = par_err_q;
    assign bus.frame_err  = frm_err_q;
    assign bus.busy       = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        perr_d    = perr_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.rx) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Re-check the line mid start bit to reject single-cycle glitches.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = bus.rx ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        if (idx_q == IW'(i)) shift_d[i] = bus.rx;
                    end
                    if (idx_q == IDX_LAST) state_d = PARITY;
                    else                   idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = (^shift_q) ^ bus.rx;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    data_d    = shift_q;
                    valid_d   = 1'b1;
                    par_err_d = perr_q;
                    frm_err_d = ~bus.rx;
                    // A low stop bit means the line may be held in break; wait for it to rise.
                    state_d   = bus.rx ? IDLE : BREAK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (bus.rx) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_rx_sipo.sv
// Randomised scoreboard bench for serial_rx_sipo: frames are generated bit by bit, the expected
// word, error flags and strobe cycle are queued at send time and checked by an independent monitor.
module tb_serial_rx_sipo;
    localparam int W    = 8;
    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 1 + HALF + CPB * (W + 2);

    typedef struct {
        logic [W-1:0] d;
        logic         pe;
        logic         fe;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic res;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    serial_rx_sipo_if #(.WIDTH(W)) bus ();

    serial_rx_sipo #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!res && bus.valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got data %0h at cycle %0d, expected no strobe", bus.data_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_out",   int'(bus.data_out),   int'(e.d));
                chk("parity_err", int'(bus.parity_err), int'(e.pe));
                chk("frame_err",  int'(bus.frame_err),  int'(e.fe));
                chk("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (CPB) tick();
    endtask

    // Reference: the receiver must report the word, even-parity mismatch and low stop bit.
    task automatic send_frame(input logic [W-1:0] d, input logic p, input logic s);
        exp_t e;
        logic [W+2:0] bits;
        e.d   = d;
        e.pe  = (^d) ^ p;
        e.fe  = ~s;
        e.cyc = cyc + LAT;
        sb.push_back(e);
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < W + 3; i++) drive_bit(bits[i]);
    endtask

    initial begin
        int busy_cnt;
        int wait_cyc;
        logic [W-1:0] rd;
        logic [W-1:0] last_d;

        res    = 1'b1;
        bus.rx = 1'b1;
        repeat (2) tick();
        chk("rst_data_out",   int'(bus.data_out),   0);
        chk("rst_valid",      int'(bus.valid),      0);
        chk("rst_parity_err", int'(bus.parity_err), 0);
        chk("rst_frame_err",  int'(bus.frame_err),  0);
        chk("rst_busy",       int'(bus.busy),       0);
        res = 1'b0;
        idle(3);

        send_frame(8'hA5, 1'b0, 1'b1);
        idle(3);
        chk("hold_after_good", int'(bus.data_out), 'hA5);

        send_frame(8'h01, 1'b0, 1'b1);
        idle(3);

        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20) tick();
        chk("busy_in_break", int'(bus.busy), 1);
        idle(2);
        chk("busy_after_break", int'(bus.busy), 0);

        busy_cnt = 0;
        bus.rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.busy) busy_cnt++;
            if (i == 0) bus.rx = 1'b1;
        end
        chk("glitch_busy_cycles", busy_cnt, HALF);

        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h00, 1'b0, 1'b1);
        idle(3);

        rd = 8'h5A;
        drive_bit(1'b0);
        for (int k = 0; k < 4; k++) drive_bit(rd[k]);
        bus.rx = rd[4];
        tick();
        res = 1'b1;
        tick();
        res = 1'b0;
        bus.rx = 1'b1;
        chk("midrst_busy",     int'(bus.busy),     0);
        chk("midrst_data_out", int'(bus.data_out), 0);
        chk("midrst_valid",    int'(bus.valid),    0);
        idle(CPB * (W + 3));
        send_frame(8'h81, 1'b0, 1'b1);
        idle(2);

        last_d = 8'h81;
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] d;
            logic p;
            logic s;
            d = W'($urandom_range(0, (1 << W) - 1));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, p, s);
            last_d = d;
            if (s) idle($urandom_range(0, 3));
            else   idle($urandom_range(1, 3));
        end
        idle(4);
        chk("final_hold", int'(bus.data_out), int'(last_d));

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 200) begin
            tick();
            wait_cyc++;
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_rx_sipo.md
# serial_rx_sipo

Serial-in, parallel-out frame receiver for the single-wire link in the tutorial blocks. It samples a serial line `rx` that idles high and recognises frames made of a start bit, WIDTH data bits sent LSB-first, an even-parity bit and a stop bit. For each completed frame it presents the parallel word, a one-cycle `valid` strobe and error flags. It sits at the receiving end of the link, in the same clock domain as the sender.

## Interface
- `WIDTH`, default 8: number of data bits per frame, 1..16.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be even and ≥2. HALF = CLKS_PER_BIT/2.

Ports (single clock; reset is synchronous and active-high):
- `clk` input 1: clock. All state changes on its rising edge.
- `res` input 1: synchronous active-high reset.
- `rx` input 1: serial line, idle = 1. Synchronous to `clk`; no synchronizer inside.
- `data_out` output WIDTH: last received word. Held until the next frame completes.
- `valid` output 1: one-cycle pulse when a frame completes.
- `parity_err` output 1: pulses with `valid` when even parity fails.
- `frame_err` output 1: pulses with `valid` when the stop bit is sampled as 0.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- Bit counter `cnt` is width clog2(CLKS_PER_BIT). Bit index `idx` is width clog2(WIDTH+1).
- IDLE:
  - `rx`=0 at an edge → START, `cnt`=0.
- START:
  - Increment `cnt` each edge.
  - At the edge where `cnt`==HALF-1, sample `rx`:
    - `rx`=1 → false start, go to IDLE, no outputs.
    - `rx`=0 → go to DATA with `cnt`=0, `idx`=0.
- DATA:
  - Sample at the edge where `cnt`==CLKS_PER_BIT-1, then set `cnt`=0.
  - Shift register fills LSB-first: bit `idx` gets `rx`.
  - After bit WIDTH-1 → PARITY.
- PARITY:
  - Sample at `cnt`==CLKS_PER_BIT-1.
  - Store `perr` = XOR of the data bits XOR the parity bit (even parity: 1 means error).
  - Then go to STOP.
- STOP, at the `cnt`==CLKS_PER_BIT-1 edge:
  - Load `data_out` from the shift register.
  - Assert `valid`=1, `parity_err`=`perr`, `frame_err`=~`rx`.
  - Next state: IDLE if `rx`=1, BREAK if `rx`=0.
- A frame with errors still updates `data_out` and still pulses `valid`.
- BREAK: wait until `rx`=1, then go to IDLE. A line held low is never taken as a new start bit.
- `valid`, `parity_err` and `frame_err` are registered and are 0 on every cycle except the single cycle after the STOP sample edge.
- Reset: `res`=1 at any edge, including mid-frame, forces:
  - state IDLE, `cnt`=0, `idx`=0;
  - shift register 0, `data_out`=0;
  - `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
- Reset takes priority over all sampling. A frame cut by reset never produces `valid`.

## Timing
- E0 is the edge at which IDLE first sees `rx`=0.
- Start-bit check: E0+HALF.
- Data bit k: E0+HALF+CLKS_PER_BIT·(k+1).
- Parity: E0+HALF+CLKS_PER_BIT·(WIDTH+1).
- Stop: E0+HALF+CLKS_PER_BIT·(WIDTH+2). With defaults this is E0+42.
- `valid` is high for exactly one cycle after the stop edge.
- `busy` rises the cycle after E0 and falls the cycle after the stop edge. When going to BREAK, it falls after leaving BREAK.
- Back-to-back frames: the next start bit may begin on the cycle after the stop bit period ends. IDLE detects it at the first edge where `rx`=0. Zero idle bits are legal.
- Max throughput: one word per CLKS_PER_BIT·(WIDTH+3) cycles.

## Test plan
- Reset check: `res`=1 for 2 cycles, `rx`=1 → all outputs 0, `busy`=0.
- Good frame: defaults, send 0xA5 with parity 0 and stop 1 → `data_out`=0xA5, `valid` high 1 cycle at E0+42 (+1 register), `parity_err`=0, `frame_err`=0.
- Parity error: send 0x01 with parity bit 0 → `data_out`=0x01, `valid`=1, `parity_err`=1, `frame_err`=0.
- Framing error and BREAK: send 0x3C with stop bit 0, then hold `rx`=0 for 20 cycles, then release to 1 → `frame_err`=1 once, `busy` stays 1 until `rx`=1, and no second `valid`.
- False start and glitch: a `rx`=0 pulse of 1 cycle → `busy` pulses for HALF cycles, no `valid`. Then send two frames back-to-back, 0xFF then 0x00 → two `valid` pulses 44 cycles apart.
- Mid-frame reset: assert `res` during data bit 4 of 0x5A, then send a good frame 0x81 → no `valid` for 0x5A, then `data_out`=0x81 with `valid`.
